// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding a start/8-data/parity/stop serialiser.
// Mode and rate are captured when a byte is popped and stay fixed for that frame.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_full,
  input  logic                 uart_enable,
  input  logic [2:0]           uart_mode,
  input  logic [15:0]          uart_rate,
  output logic                 txd,
  output logic                 uart_busy,
  output logic                 uart_error,
  output logic                 update_ok
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state, state_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [DATA_BITS-1:0] head;

  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_q, par_d;
  logic [15:0]          cnt, cnt_d;
  logic [15:0]          rate_q, rate_d;
  logic [2:0]           mode_q, mode_d;
  logic [BW-1:0]        bit_idx, bit_idx_d;
  logic                 stop_idx, stop_idx_d;
  logic                 txd_d;

  logic fifo_empty, pop, rate_ok, start_frame, rate_err;
  logic wr_accept, ovf_err, bit_done;

  assign fifo_empty  = (count == '0);
  assign tx_full     = (count == CW'(FIFO_DEPTH));
  assign head        = mem[rd_ptr];
  assign pop         = (state == IDLE) && !fifo_empty && uart_enable;
  assign rate_ok     = (uart_rate >= 16'd2);
  assign start_frame = pop && rate_ok;
  // A byte popped with an illegal rate is discarded rather than left to block the FIFO.
  assign rate_err    = pop && !rate_ok;
  assign wr_accept   = tx_wr && (!tx_full || pop);
  assign ovf_err     = tx_wr && !wr_accept;
  assign bit_done    = (cnt == '0);

  assign uart_busy   = (state != IDLE) || !fifo_empty;
  assign update_ok   = !uart_busy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_frame) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && bit_idx == BW'(DATA_BITS - 1))
                 state_d = mode_q[0] ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done && (stop_idx || !mode_q[2])) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // txd is registered, so it is derived from the next state and next shift value.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    shreg_d    = shreg;
    par_d      = par_q;
    cnt_d      = cnt;
    rate_d     = rate_q;
    mode_d     = mode_q;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    if (start_frame) begin
      shreg_d    = head;
      par_d      = (^head) ^ uart_mode[1];
      mode_d     = uart_mode;
      rate_d     = uart_rate;
      cnt_d      = uart_rate - 16'd1;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
    end else if (state != IDLE) begin
      if (bit_done) begin
        cnt_d = rate_q - 16'd1;
        if (state == DATA) begin
          if (bit_idx != BW'(DATA_BITS - 1)) shreg_d = shreg >> 1;
          bit_idx_d = bit_idx + 1'b1;
        end
        if (state == STOP) stop_idx_d = 1'b1;
      end else begin
        cnt_d = cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      par_q    <= 1'b0;
      cnt      <= '0;
      rate_q   <= '0;
      mode_q   <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      txd      <= 1'b1;
    end else begin
      shreg    <= shreg_d;
      par_q    <= par_d;
      cnt      <= cnt_d;
      rate_q   <= rate_d;
      mode_q   <= mode_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      txd      <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      uart_error <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      count      <= count + CW'(wr_accept) - CW'(pop);
      uart_error <= ovf_err | rate_err;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: stimulus queues expected frames, a txd monitor
// decodes each frame cycle-by-cycle and checks it against the queue.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        tx_full;
  logic        uart_enable;
  logic [2:0]  uart_mode;
  logic [15:0] uart_rate;
  logic        txd;
  logic        uart_busy;
  logic        uart_error;
  logic        update_ok;

  uart_tx_engine #(.FIFO_DEPTH(4), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .uart_enable(uart_enable), .uart_mode(uart_mode), .uart_rate(uart_rate),
    .txd(txd), .uart_busy(uart_busy), .uart_error(uart_error), .update_ok(update_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] rate;
    logic [2:0]  mode;
    logic        par;
    int unsigned len;
    bit          gap;
    bit          last;
    bit          abort_ok;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          frames_seen = 0;
  int          err_seen = 0;
  longint      cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (uart_error === 1'b1) err_seen <= err_seen + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic [15:0] r, input logic [2:0] m,
                              input logic p, input int unsigned len, input bit gap,
                              input bit last, input bit ab);
    exp_t e;
    e.data = d; e.rate = r; e.mode = m; e.par = p; e.len = len;
    e.gap = gap; e.last = last; e.abort_ok = ab;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned max);
    bit done = 1'b0;
    for (int unsigned k = 0; k < max; k++) begin
      @(negedge clk);
      if (update_ok === 1'b1 && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk({"idle_", tag}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t        e;
    int unsigned mism, uo_bad, b;
    logic        eb;
    bit          ab;
    longint      last_start = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || txd !== 1'b0) continue;
      if (sb.size() == 0) begin
        chk("unexpected_start", 32'd1, 32'd0);
        for (int k = 0; k < 70000 && txd === 1'b0; k++) @(negedge clk);
        continue;
      end
      e = sb.pop_front();
      if (e.gap) chk($sformatf("start_gap_%02h", e.data), 32'(cyc - last_start), 32'(e.len + 1));
      last_start = cyc;
      mism = 0; uo_bad = 0; ab = 1'b0;
      for (int unsigned c = 0; c < e.len; c++) begin
        if (c != 0) @(negedge clk);
        if (rst === 1'b1) begin
          ab = 1'b1;
          break;
        end
        b = c / 32'(e.rate);
        if (b == 0)                      eb = 1'b0;
        else if (b <= 8)                 eb = e.data[b-1];
        else if (b == 9 && e.mode[0])    eb = e.par;
        else                             eb = 1'b1;
        if (txd !== eb) mism++;
        if (update_ok !== 1'b0) uo_bad++;
      end
      if (ab) begin
        chk($sformatf("abort_allowed_%02h", e.data), 32'(e.abort_ok), 32'd1);
      end else begin
        chk($sformatf("frame_bits_%02h", e.data), mism, 32'd0);
        chk($sformatf("frame_update_ok_low_%02h", e.data), uo_bad, 32'd0);
        @(negedge clk);
        chk($sformatf("post_frame_txd_%02h", e.data), 32'(txd), 32'd1);
        if (e.last) chk($sformatf("post_frame_update_ok_%02h", e.data), 32'(update_ok), 32'd1);
        frames_seen++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e0, f0;
    rst = 1'b1; tx_wr = 1'b0; tx_data = '0;
    uart_enable = 1'b1; uart_mode = 3'b000; uart_rate = 16'd4;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    chk("rst_busy", 32'(uart_busy), 32'd0);
    chk("rst_error", 32'(uart_error), 32'd0);
    chk("rst_update_ok", 32'(update_ok), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // basic frame, 0xA5 at rate 4
    expect_frame(8'hA5, 16'd4, 3'b000, 1'b0, 40, 1'b0, 1'b1, 1'b0);
    wr(8'hA5);
    chk("latency_still_idle", 32'(txd), 32'd1);
    @(negedge clk);
    chk("latency_start_bit", 32'(txd), 32'd0);
    chk("busy_in_frame", 32'(uart_busy), 32'd1);
    wait_idle("basic", 200);

    // parity / stop-bit variants of 0x03
    uart_mode = 3'b001;
    expect_frame(8'h03, 16'd4, 3'b001, 1'b0, 44, 1'b0, 1'b1, 1'b0);
    wr(8'h03);
    wait_idle("par_even", 200);
    uart_mode = 3'b011;
    expect_frame(8'h03, 16'd4, 3'b011, 1'b1, 44, 1'b0, 1'b1, 1'b0);
    wr(8'h03);
    wait_idle("par_odd", 200);
    uart_mode = 3'b101;
    expect_frame(8'h03, 16'd4, 3'b101, 1'b0, 48, 1'b0, 1'b1, 1'b0);
    wr(8'h03);
    wait_idle("two_stop", 200);

    // overflow: six writes into a 4-deep FIFO while the first byte is popped
    uart_mode = 3'b000;
    e0 = err_seen;
    expect_frame(8'h10, 16'd4, 3'b000, 1'b0, 40, 1'b0, 1'b0, 1'b0);
    expect_frame(8'h11, 16'd4, 3'b000, 1'b0, 40, 1'b1, 1'b0, 1'b0);
    expect_frame(8'h12, 16'd4, 3'b000, 1'b0, 40, 1'b1, 1'b0, 1'b0);
    expect_frame(8'h13, 16'd4, 3'b000, 1'b0, 40, 1'b1, 1'b0, 1'b0);
    expect_frame(8'h14, 16'd4, 3'b000, 1'b0, 40, 1'b1, 1'b1, 1'b0);
    wr(8'h10); wr(8'h11); wr(8'h12); wr(8'h13);
    chk("not_full_after_4", 32'(tx_full), 32'd0);
    wr(8'h14);
    chk("full_after_5", 32'(tx_full), 32'd1);
    wr(8'h15);
    chk("ovf_error_pulse", 32'(uart_error), 32'd1);
    chk("full_after_drop", 32'(tx_full), 32'd1);
    @(negedge clk);
    chk("ovf_error_one_cycle", 32'(uart_error), 32'd0);
    wait_idle("overflow", 600);
    chk("ovf_error_count", 32'(err_seen - e0), 32'd1);

    // illegal rate: byte discarded, error pulse, line stays idle
    uart_rate = 16'd1;
    e0 = err_seen;
    wr(8'h55);
    chk("illegal_busy_queued", 32'(uart_busy), 32'd1);
    chk("illegal_error_not_yet", 32'(uart_error), 32'd0);
    @(negedge clk);
    chk("illegal_error_pulse", 32'(uart_error), 32'd1);
    chk("illegal_busy_cleared", 32'(uart_busy), 32'd0);
    chk("illegal_txd_idle", 32'(txd), 32'd1);
    @(negedge clk);
    chk("illegal_error_one_cycle", 32'(uart_error), 32'd0);
    repeat (3) @(negedge clk);
    chk("illegal_error_count", 32'(err_seen - e0), 32'd1);
    uart_rate = 16'd4;

    // disable and reconfigure mid-frame; frame 1 keeps rate 4, the rest use rate 8 odd parity
    f0 = frames_seen;
    expect_frame(8'h3C, 16'd4, 3'b000, 1'b0, 40, 1'b0, 1'b0, 1'b0);
    wr(8'h3C); wr(8'h81); wr(8'h7E);
    repeat (6) @(negedge clk);
    uart_enable = 1'b0;
    uart_rate   = 16'd8;
    uart_mode   = 3'b011;
    repeat (80) @(negedge clk);
    chk("paused_frames", 32'(frames_seen - f0), 32'd1);
    chk("paused_busy", 32'(uart_busy), 32'd1);
    chk("paused_update_ok", 32'(update_ok), 32'd0);
    chk("paused_txd", 32'(txd), 32'd1);
    expect_frame(8'h81, 16'd8, 3'b011, 1'b1, 88, 1'b0, 1'b0, 1'b0);
    expect_frame(8'h7E, 16'd8, 3'b011, 1'b1, 88, 1'b1, 1'b1, 1'b0);
    uart_enable = 1'b1;
    wait_idle("reenable", 400);
    chk("reenable_frames", 32'(frames_seen - f0), 32'd3);

    // reset during DATA with three bytes queued
    uart_rate = 16'd4;
    uart_mode = 3'b000;
    expect_frame(8'h5A, 16'd4, 3'b000, 1'b0, 40, 1'b0, 1'b0, 1'b1);
    wr(8'h5A); wr(8'h11); wr(8'h22); wr(8'h33);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_update_ok", 32'(update_ok), 32'd1);
    chk("midrst_tx_full", 32'(tx_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    f0 = frames_seen;
    repeat (100) @(negedge clk);
    chk("postrst_no_frames", 32'(frames_seen - f0), 32'd0);
    chk("postrst_queue_drained", 32'(sb.size()), 32'd0);
    chk("postrst_update_ok", 32'(update_ok), 32'd1);
    chk("postrst_txd", 32'(txd), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

UART transmit engine that consumes the control/status register file's system interface. It takes `uart_enable`, `uart_mode` and `uart_rate` from the register file and returns `uart_busy`, `uart_error` and `update_ok`. Host bytes enter through a small write-strobe FIFO. The engine serialises them onto `txd` as start / 8 data / optional parity / 1–2 stop frames. Configuration is latched per frame. `update_ok` tells the register file when the baud shadow register may be committed safely.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `DATA_BITS`, 8: data bits per frame; fixed at 8 for this revision.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `tx_wr` in 1: write strobe; byte sampled on the edge where `tx_wr`=1.
- `tx_data` in 8: byte to transmit.
- `tx_full` out 1: FIFO full (registered count == `FIFO_DEPTH`).
- `uart_enable` in 1: 1 = frames may start.
- `uart_mode` in 3: [0] parity enable, [1] parity odd (1) / even (0), [2] two stop bits.
- `uart_rate` in 16: clk cycles per bit.
- `txd` out 1: serial line, registered, idle high.
- `uart_busy` out 1: FSM not IDLE, or FIFO not empty.
- `uart_error` out 1: one-cycle error pulse.
- `update_ok` out 1: FSM in IDLE and FIFO empty.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when FIFO non-empty, `uart_enable`=1 and latched-rate check passes. On that edge:
  - pop the head byte into the shift register;
  - latch `uart_mode` and `uart_rate`;
  - load the bit counter with rate-1.
- Rate check: if `uart_rate` < 2 at a pop, the byte is popped and discarded, `uart_error` pulses, and the FSM stays IDLE.
- Every bit lasts exactly latched-rate cycles; the counter counts down to 0, then the next bit starts.
- START drives `txd`=0.
- DATA drives bits 0..7, LSB first.
- PARITY is entered only if mode[0]=1:
  - even: bit = XOR of data;
  - odd: bit = ~XOR of data.
- STOP drives `txd`=1 for 1 bit time, or 2 if mode[2]=1, then returns to IDLE.
- Frame length = rate × (10 + mode[0] + mode[2]) cycles.
- `uart_enable` falling mid-frame: the current frame completes; no new frame starts; FIFO contents are retained.
- Changes to `uart_mode`/`uart_rate` mid-frame have no effect until the next pop.
- FIFO write:
  - accepted if not full, or if a pop occurs on the same edge;
  - otherwise the byte is dropped and `uart_error` pulses the following cycle.
- Writes are accepted while `uart_enable`=0.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is kept with width clog2(`FIFO_DEPTH`)+1.
- Overflow and rate errors on the same edge produce a single one-cycle pulse.

## Timing
- Reset values:
  - `txd`=1, `tx_full`=0, `uart_busy`=0, `uart_error`=0, `update_ok`=1;
  - FIFO empty, FSM IDLE.
- Reset mid-frame: `txd`=1 from the cycle after the reset edge; the frame is aborted and FIFO contents are lost.
- Write latency into an idle engine:
  - `tx_wr` sampled at edge k;
  - pop and START entered at edge k+1;
  - `txd`=0 from edge k+1.
- Back-to-back frames: exactly one IDLE cycle (`txd`=1) between the last stop bit and the next start bit.
- `uart_busy` and `update_ok` are combinational from registered state; each is the complement of the other.
- `update_ok` rises in the IDLE cycle after the last stop bit when the FIFO is empty.
- `uart_error` is registered: high for exactly one cycle per error event.

## Test plan
- Basic frame:
  - stimulus: rate=4, mode=3'b000, write 0xA5;
  - response: `txd` 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles;
  - frame is 40 cycles; `update_ok`=0 throughout, 1 after.
- Parity and stop bits:
  - 0x03 with mode=3'b001 → parity bit 0, frame 44 cycles;
  - mode=3'b011 → parity bit 1;
  - mode=3'b101 → 2 stop bits, frame 48 cycles.
- Overflow:
  - stimulus: `FIFO_DEPTH`=4, rate=4, six consecutive `tx_wr` with 0x10..0x15;
  - response: first five accepted, `tx_full`=1 after the 5th write;
  - the 6th write dropped with one `uart_error` pulse; 0x10..0x14 transmitted in order, each separated by 1 idle cycle.
- Illegal rate:
  - stimulus: rate=1, write 0x55;
  - response: one `uart_error` pulse, `txd` stays 1, `uart_busy` returns to 0 two cycles after the write.
- Enable and mid-frame config:
  - stimulus: `uart_enable` deasserted during DATA of frame 1, with 2 bytes queued; `uart_rate` changed 4→8 mid-frame;
  - response: frame 1 completes at rate 4; no further start bit; `uart_busy`=1 remains;
  - re-enable → next frames run at rate 8.
- Reset mid-frame:
  - stimulus: `rst` asserted during DATA with 3 bytes queued;
  - response: `txd`=1 next cycle, `update_ok`=1, `tx_full`=0, nothing transmitted after reset release.
